// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: glyph constants, decoder FSM encoding and glyph lookup.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGIT_W = 4;

  // Active-high glyphs, bit0 = segment a .. bit6 = segment g
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'h71;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic               err;
    logic               blank;
    logic [DIGIT_W-1:0] digit;
  } glyph_t;

  // Digit is forced to 0 for blank and unknown patterns
  function automatic glyph_t seg7_glyph_lookup(input logic [SEG_W-1:0] pat);
    glyph_t r;
    r = '{err: 1'b0, blank: 1'b0, digit: 4'h0};
    case (pat)
      GLYPH_0:     r.digit = 4'h0;
      GLYPH_1:     r.digit = 4'h1;
      GLYPH_2:     r.digit = 4'h2;
      GLYPH_3:     r.digit = 4'h3;
      GLYPH_4:     r.digit = 4'h4;
      GLYPH_5:     r.digit = 4'h5;
      GLYPH_6:     r.digit = 4'h6;
      GLYPH_7:     r.digit = 4'h7;
      GLYPH_8:     r.digit = 4'h8;
      GLYPH_9:     r.digit = 4'h9;
      GLYPH_A:     r.digit = 4'hA;
      GLYPH_B:     r.digit = 4'hB;
      GLYPH_C:     r.digit = 4'hC;
      GLYPH_D:     r.digit = 4'hD;
      GLYPH_E:     r.digit = 4'hE;
      GLYPH_F:     r.digit = 4'hF;
      GLYPH_BLANK: r.blank = 1'b1;
      default:     r.err   = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder_if.sv
// Decoded-digit event channel: valid/ready handshake plus the event payload.
interface seg7_pattern_decoder_if;
  import seg7_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_err;
  logic               out_blank;

  modport master (output out_valid, output out_digit, output out_err, output out_blank,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_digit, input  out_err, input  out_blank,
                  output out_ready);
endinterface

// File: rtl/seg7_sync_stab.sv
// Segment bus synchroniser, polarity normalisation and stability counter.
module seg7_sync_stab
  import seg7_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_in,
  output logic [SEG_W-1:0] pat_c,
  output logic             change_c,
  output logic             stable_c
);

  localparam int unsigned      CNT_W     = 8;
  localparam logic [SEG_W-1:0] POL       = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0] BLANK_RAW = GLYPH_BLANK ^ POL;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ARM   = CNT_W'(STABLE_CYCLES - 2);

  logic [SEG_W-1:0] sync_q [SYNC_STAGES];
  logic [SEG_W-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q;

  // Raw bus goes straight into the first flop; inversion happens after synchronisation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= BLANK_RAW;
    end else begin
      sync_q[0] <= seg_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pat_c    = sync_q[SYNC_STAGES-1] ^ POL;
  assign change_c = (pat_c != prev_q);
  // Asserted in the cycle whose edge brings cnt to STABLE_CYCLES-1
  assign stable_c = !change_c && (cnt_q >= CNT_ARM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= GLYPH_BLANK;
      cnt_q  <= '0;
    end else begin
      prev_q <= pat_c;
      if (change_c)              cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Decodes a settled 7-segment pattern back to a hex digit and emits one event per change.
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SEG_W-1:0]               seg_in,
  seg7_pattern_decoder_if.master         evt,
  output logic                           overflow,
  input  logic                           clr_ovf
);

  logic [SEG_W-1:0]   pat_c;
  logic               change_c;
  logic               stable_c;
  state_t             state_q, state_d;
  logic               event_c;
  glyph_t             dec_c;
  logic               last_vld_q;
  logic [SEG_W-1:0]   last_pat_q;
  logic               valid_q;
  logic [DIGIT_W-1:0] digit_q;
  logic               err_q;
  logic               blank_q;
  logic               ovf_q;

  seg7_sync_stab #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
    .SYNC_STAGES    (SYNC_STAGES),
    .STABLE_CYCLES  (STABLE_CYCLES)
  ) u_sync_stab (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .pat_c    (pat_c),
    .change_c (change_c),
    .stable_c (stable_c)
  );

  assign dec_c = seg7_glyph_lookup(pat_c);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_SETTLE;
    else        state_q <= state_d;
  end

  // Settling back onto the last emitted pattern locks silently
  always_comb begin
    state_d = state_q;
    event_c = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (stable_c) begin
          state_d = ST_LOCKED;
          event_c = !(last_vld_q && (pat_c == last_pat_q));
        end
      end
      ST_LOCKED: begin
        if (change_c) state_d = ST_SETTLE;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_vld_q <= 1'b0;
      last_pat_q <= GLYPH_BLANK;
    end else if (event_c) begin
      last_vld_q <= 1'b1;
      last_pat_q <= pat_c;
    end
  end

  // Single-entry output stage; a new event may replace an entry being accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      digit_q <= '0;
      err_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (event_c && (!valid_q || evt.out_ready)) begin
        valid_q <= 1'b1;
        digit_q <= dec_c.digit;
        err_q   <= dec_c.err;
        blank_q <= dec_c.blank;
      end else if (evt.out_ready) begin
        valid_q <= 1'b0;
      end
      if (event_c && valid_q && !evt.out_ready) ovf_q <= 1'b1;
      else if (clr_ovf)                         ovf_q <= 1'b0;
    end
  end

  assign evt.out_valid = valid_q;
  assign evt.out_digit = digit_q;
  assign evt.out_err   = err_q;
  assign evt.out_blank = blank_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Scoreboard bench for seg7_pattern_decoder with directed segment-bus vectors.
module tb_seg7_pattern_decoder;

  localparam int LAT = 6;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] digit;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_ovf;
  logic [6:0] seg_in;
  logic       overflow;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_pattern_decoder_if bus ();

  seg7_pattern_decoder #(
    .SEG_ACTIVE_LOW (1'b1),
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .evt      (bus),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    32'(bus.out_valid), 0);
    check({tag, "_digit"},    32'(bus.out_digit), 0);
    check({tag, "_err"},      32'(bus.out_err),   0);
    check({tag, "_blank"},    32'(bus.out_blank), 0);
    check({tag, "_overflow"}, 32'(overflow),      0);
  endtask

  // Monitor: every accepted event must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({bus.out_err, bus.out_blank, bus.out_digit}), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event", 32'({bus.out_err, bus.out_blank, bus.out_digit}), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;

    // 1: reset, then active-low "0" emits after the full latency
    rst_n         = 1'b0;
    seg_in        = 7'h40;
    bus.out_ready = 1'b1;
    clr_ovf       = 1'b0;
    step(2);
    check_reset_outputs("reset");
    exp_q.push_back(exp_t'{1'b0, 1'b0, 4'h0});
    rst_n = 1'b1;
    wait_valid(lat);
    check("latency_first", 32'(lat), 32'(LAT));
    step(4);

    // 2: short glitch to "1" and back produces nothing
    seg_in = 7'h79;
    step(2);
    seg_in = 7'h40;
    seen   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("glitch_no_event", 32'(seen), 0);

    // 3: consumer stalled; "3" held, "A" dropped, overflow sticky until cleared
    bus.out_ready = 1'b0;
    seg_in = 7'h30;
    exp_q.push_back(exp_t'{1'b0, 1'b0, 4'h3});
    step(8);
    check("stall_valid", 32'(bus.out_valid), 1);
    check("stall_digit", 32'(bus.out_digit), 3);
    check("stall_no_ovf", 32'(overflow), 0);
    seg_in = 7'h08;
    step(8);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_valid_held", 32'(bus.out_valid), 1);
    check("drop_digit_held", 32'(bus.out_digit), 3);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    check("clr_overflow", 32'(overflow), 0);
    bus.out_ready = 1'b1;
    step(2);
    check("drained_valid", 32'(bus.out_valid), 0);

    // 4: unknown pattern then blank
    seg_in = 7'h7E;
    exp_q.push_back(exp_t'{1'b1, 1'b0, 4'h0});
    step(8);
    seg_in = 7'h7F;
    exp_q.push_back(exp_t'{1'b0, 1'b1, 4'h0});
    step(8);

    // 5: sweep all glyphs with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      seg_in = ~glyphs[i];
      exp_q.push_back(exp_t'{1'b0, 1'b0, 4'(i)});
      step(5);
    end
    step(8);
    check("sweep_no_overflow", 32'(overflow), 0);
    check("sweep_drained", 32'(exp_q.size()), 0);

    // 6: reset mid-settle of "5", then "5" emits after the full latency
    seg_in = 7'h12;
    step(2);
    rst_n = 1'b0;
    step(1);
    check_reset_outputs("midreset");
    exp_q.push_back(exp_t'{1'b0, 1'b0, 4'h5});
    rst_n = 1'b1;
    wait_valid(lat);
    check("latency_after_reset", 32'(lat), 32'(LAT));
    step(4);
    check("final_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
